// File: rtl/letc_timer.sv
// Machine timer: 64-bit mtime/mtimecmp behind a single-outstanding register bus,
// with a prescaled mtime tick and a registered (mtime >= mtimecmp) interrupt.
module letc_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [4:0]  i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_error,
  output logic        o_timer_irq_pending
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic [2:0] IDX_MTIME_LO    = 3'd0;
  localparam logic [2:0] IDX_MTIME_HI    = 3'd1;
  localparam logic [2:0] IDX_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] IDX_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] IDX_CTRL        = 3'd4;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic             enable_q, enable_d;
  logic [CNT_W-1:0] presc_cnt_q, presc_cnt_d;
  logic             irq_q, irq_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_error_q, rsp_error_d;

  logic        accept;
  logic [2:0]  req_idx;
  logic        idx_legal;
  logic        wr_en;
  logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
  logic        tick;
  logic [31:0] rd_val;
  logic        unused_addr_lsb;

  // Byte offset within a word carries no meaning on this bus.
  assign unused_addr_lsb = ^i_req_addr[1:0];

  assign accept    = i_req_valid && (state_q == ST_IDLE);
  assign req_idx   = i_req_addr[4:2];
  assign idx_legal = (req_idx <= IDX_CTRL);
  assign wr_en     = accept && i_req_wen && idx_legal;

  assign wr_mtime_lo = wr_en && (req_idx == IDX_MTIME_LO);
  assign wr_mtime_hi = wr_en && (req_idx == IDX_MTIME_HI);
  assign wr_cmp_lo   = wr_en && (req_idx == IDX_MTIMECMP_LO);
  assign wr_cmp_hi   = wr_en && (req_idx == IDX_MTIMECMP_HI);
  assign wr_ctrl     = wr_en && (req_idx == IDX_CTRL);

  assign tick = enable_q && (presc_cnt_q == CNT_LAST);

  // Read data always reflects pre-edge register contents.
  always_comb begin
    rd_val = 32'd0;
    case (req_idx)
      IDX_MTIME_LO:    rd_val = mtime_q[31:0];
      IDX_MTIME_HI:    rd_val = mtime_q[63:32];
      IDX_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
      IDX_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
      IDX_CTRL:        rd_val = {31'd0, enable_q};
      default:         rd_val = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_req_valid) state_d = ST_RESP;
      ST_RESP: if (i_rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    if (accept) begin
      rsp_rdata_d = (!i_req_wen && idx_legal) ? rd_val : 32'd0;
      rsp_error_d = !idx_legal;
    end
  end

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    if (enable_q) begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
    end
  end

  // A bus write to either mtime half overrides the tick for that edge.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_mtime_lo) begin
      mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], i_req_wdata, i_req_wstrb)};
    end else if (wr_mtime_hi) begin
      mtime_d = {merge_bytes(mtime_q[63:32], i_req_wdata, i_req_wstrb), mtime_q[31:0]};
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr_cmp_lo) begin
      mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], i_req_wdata, i_req_wstrb);
    end
    if (wr_cmp_hi) begin
      mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], i_req_wdata, i_req_wstrb);
    end
  end

  always_comb begin
    enable_d = enable_q;
    if (wr_ctrl && i_req_wstrb[0]) enable_d = i_req_wdata[0];
  end

  assign irq_d = (mtime_q >= mtimecmp_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      mtime_q     <= 64'd0;
      mtimecmp_q  <= {64{1'b1}};
      enable_q    <= 1'b0;
      presc_cnt_q <= '0;
      irq_q       <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      enable_q    <= enable_d;
      presc_cnt_q <= presc_cnt_d;
      irq_q       <= irq_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign o_req_ready         = (state_q == ST_IDLE);
  assign o_rsp_valid         = (state_q == ST_RESP);
  assign o_rsp_rdata         = rsp_rdata_q;
  assign o_rsp_error         = rsp_error_q;
  assign o_timer_irq_pending = irq_q;

endmodule

// File: tb/tb_letc_timer.sv
// Directed bench for letc_timer: a PRESCALE=1 and a PRESCALE=4 instance share one bus.
module tb_letc_timer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_wen;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_ready;

  logic        req_ready1, rsp_valid1, rsp_error1, irq1;
  logic [31:0] rsp_rdata1;
  logic        req_ready4, rsp_valid4, rsp_error4, irq4;
  logic [31:0] rsp_rdata4;

  int errors = 0;
  int checks = 0;

  letc_timer #(.PRESCALE(1)) u1 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready1), .i_req_wen(req_wen),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata1),
    .o_rsp_error(rsp_error1), .o_timer_irq_pending(irq1)
  );

  letc_timer #(.PRESCALE(4)) u4 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready4), .i_req_wen(req_wen),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_rsp_valid(rsp_valid4), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata4),
    .o_rsp_error(rsp_error4), .o_timer_irq_pending(irq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction: accept on the first edge after the call, consume on the next.
  task automatic bus(input logic wen, input logic [4:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, output logic [31:0] rd1, output logic [31:0] rd4,
                     output logic err1, output logic vld_acc, output logic vld_after,
                     output logic irq_acc, output logic irq_after);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rd1 = rsp_rdata1; rd4 = rsp_rdata4; err1 = rsp_error1;
    vld_acc = rsp_valid1 && !req_ready1; irq_acc = irq1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    vld_after = rsp_valid1; irq_after = irq1;
  endtask

  task automatic do_reset;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd1, rd4, exp_v [5];
    logic err, va, vf, ia, ib;
    exp_v = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    do_reset();
    checks++; if (req_ready1 !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%b exp=1", req_ready1); end
    checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid1); end
    checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", irq1); end
    checks++; if (rsp_rdata1 !== 32'h0 || rsp_error1 !== 1'b0) begin
      errors++; $display("FAIL rst_rsp got=%h/%b exp=0/0", rsp_rdata1, rsp_error1); end
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, 5'(i * 4), 32'h0, 4'h0, rd1, rd4, err, va, vf, ia, ib);
      checks++; if (rd1 !== exp_v[i] || rd4 !== exp_v[i]) begin
        errors++; $display("FAIL rst_read idx=%0d got=%h/%h exp=%h", i, rd1, rd4, exp_v[i]); end
      checks++; if (va !== 1'b1 || vf !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL rst_latency idx=%0d vld_acc=%b vld_after=%b err=%b exp=1/0/0", i, va, vf, err); end
    end
  endtask

  task automatic test_prescale;
    logic [31:0] rd1, rd4;
    logic err, va, vf, ia, ib;
    do_reset();
    bus(1'b1, 5'h10, 32'h1, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    repeat (39) @(posedge clk);
    #1;
    bus(1'b0, 5'h00, 32'h0, 4'h0, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (rd4 !== 32'd10) begin errors++; $display("FAIL presc4_mtime got=%0d exp=10", rd4); end
    checks++; if (rd1 !== 32'd40) begin errors++; $display("FAIL presc1_mtime got=%0d exp=40", rd1); end
    bus(1'b1, 5'h10, 32'h0, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    for (int n = 0; n < 2; n++) begin
      bus(1'b0, 5'h00, 32'h0, 4'h0, rd1, rd4, err, va, vf, ia, ib);
      checks++; if (rd4 !== 32'd10 || rd1 !== 32'd43) begin
        errors++; $display("FAIL disabled_hold n=%0d got=%0d/%0d exp=10/43", n, rd4, rd1); end
    end
    // Held count of 3 means the first edge after re-enabling ticks.
    bus(1'b1, 5'h10, 32'h1, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    bus(1'b0, 5'h00, 32'h0, 4'h0, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (rd4 !== 32'd11 || rd1 !== 32'd44) begin
      errors++; $display("FAIL reenable got=%0d/%0d exp=11/44", rd4, rd1); end
  endtask

  task automatic test_irq;
    logic [31:0] rd1, rd4;
    logic err, va, vf, ia, ib, exp_irq;
    do_reset();
    bus(1'b1, 5'h0C, 32'h0, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    bus(1'b1, 5'h08, 32'd20, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    bus(1'b1, 5'h10, 32'h1, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    for (int k = 6; k <= 30; k++) begin
      @(posedge clk); #1;
      exp_irq = (k >= 25);
      checks++; if (irq1 !== exp_irq) begin errors++; $display("FAIL irq_rise edge=%0d got=%b exp=%b", k, irq1, exp_irq); end
    end
    bus(1'b1, 5'h08, 32'hFFFF_FFFF, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (ia !== 1'b1 || ib !== 1'b0) begin
      errors++; $display("FAIL irq_fall at_write=%b after=%b exp=1/0", ia, ib); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd1, rd4;
    logic err, va, vf, ia, ib;
    logic [3:0] exp_seq;
    exp_seq = 4'b1100;
    do_reset();
    bus(1'b1, 5'h04, 32'hFFFF_FFFF, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    bus(1'b1, 5'h00, 32'hFFFF_FFFF, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    bus(1'b1, 5'h0C, 32'h0, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    bus(1'b1, 5'h08, 32'h2, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    bus(1'b1, 5'h10, 32'h1, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (ia !== 1'b1 || ib !== 1'b1) begin
      errors++; $display("FAIL wrap_irq_allones got=%b/%b exp=1/1", ia, ib); end
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      checks++; if (irq1 !== exp_seq[j]) begin
        errors++; $display("FAIL wrap_irq step=%0d got=%b exp=%b", j, irq1, exp_seq[j]); end
    end
    bus(1'b0, 5'h00, 32'h0, 4'h0, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (rd1 !== 32'd4) begin errors++; $display("FAIL wrap_mtime_lo got=%h exp=4", rd1); end
    bus(1'b0, 5'h04, 32'h0, 4'h0, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL wrap_mtime_hi got=%h exp=0", rd1); end
  endtask

  task automatic test_error_wstrb;
    logic [31:0] rd1, rd4;
    logic err, va, vf, ia, ib;
    do_reset();
    bus(1'b0, 5'h18, 32'h0, 4'h0, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (err !== 1'b1 || rd1 !== 32'h0 || va !== 1'b1) begin
      errors++; $display("FAIL err_read got err=%b rd=%h vld=%b exp=1/0/1", err, rd1, va); end
    bus(1'b1, 5'h1C, 32'h0000_0001, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (err !== 1'b1 || rd1 !== 32'h0) begin
      errors++; $display("FAIL err_write got err=%b rd=%h exp=1/0", err, rd1); end
    bus(1'b0, 5'h10, 32'h0, 4'h0, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (rd1 !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL err_ctrl_kept got=%h/%b exp=0/0", rd1, err); end
    bus(1'b0, 5'h0C, 32'h0, 4'h0, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (rd1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL err_cmp_hi_kept got=%h exp=ffffffff", rd1); end
    bus(1'b0, 5'h00, 32'h0, 4'h0, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL err_mtime_kept got=%h exp=0", rd1); end
    bus(1'b1, 5'h08, 32'h1234_5678, 4'b0010, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (rd1 !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL wstrb_wr_rsp got=%h/%b exp=0/0", rd1, err); end
    bus(1'b0, 5'h09, 32'h0, 4'h0, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (rd1 !== 32'hFFFF_56FF) begin errors++; $display("FAIL wstrb_lane got=%h exp=ffff56ff", rd1); end
  endtask

  task automatic test_stall_reset;
    logic [31:0] rd1, rd4;
    logic err, va, vf, ia, ib;
    do_reset();
    bus(1'b1, 5'h0C, 32'h0, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    bus(1'b1, 5'h08, 32'h0, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    bus(1'b1, 5'h00, 32'hA5A5_0001, 4'hF, rd1, rd4, err, va, vf, ia, ib);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 5'h00; rsp_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (rsp_valid1 !== 1'b1 || rsp_rdata1 !== 32'hA5A5_0001) begin
      errors++; $display("FAIL stall_first got vld=%b rd=%h exp=1/a5a50001", rsp_valid1, rsp_rdata1); end
    // A new request held during RESP must not be taken.
    req_wen = 1'b1; req_addr = 5'h10; req_wdata = 32'h1; req_wstrb = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid1 !== 1'b1 || rsp_rdata1 !== 32'hA5A5_0001 || req_ready1 !== 1'b0) begin
        errors++; $display("FAIL stall_hold c=%0d got vld=%b rd=%h rdy=%b exp=1/a5a50001/0", c, rsp_valid1, rsp_rdata1, req_ready1); end
    end
    checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL stall_irq got=%b exp=1", irq1); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rsp_valid1 !== 1'b0 || req_ready1 !== 1'b1 || irq1 !== 1'b0 || rsp_rdata1 !== 32'h0) begin
      errors++; $display("FAIL async_reset got vld=%b rdy=%b irq=%b rd=%h exp=0/1/0/0", rsp_valid1, req_ready1, irq1, rsp_rdata1); end
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b1;
    bus(1'b0, 5'h10, 32'h0, 4'h0, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL post_rst_ctrl got=%h exp=0", rd1); end
    bus(1'b0, 5'h00, 32'h0, 4'h0, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL post_rst_mtime got=%h exp=0", rd1); end
    bus(1'b0, 5'h08, 32'h0, 4'h0, rd1, rd4, err, va, vf, ia, ib);
    checks++; if (rd1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_rst_cmp got=%h exp=ffffffff", rd1); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_prescale();
    test_irq();
    test_wrap();
    test_error_wstrb();
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
